// File: rtl/lzs_pkg.sv
// lzs_pkg: shared state encoding, width helper and default geometry for the
// LZS bit packer and its output FIFO.
package lzs_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } lzs_state_e;

    // Ceiling log2, usable in constant expressions for port/param widths.
    function automatic int lzs_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    localparam int LZS_CODE_W     = 13;
    localparam int LZS_LEN_W      = 4;
    localparam int LZS_WORD_W     = 16;
    localparam int LZS_OUT_W      = 64;
    localparam int LZS_FIFO_DEPTH = 4;

    // Derived widths for the default geometry.
    localparam int LZS_ACC_W   = LZS_CODE_W + LZS_WORD_W - 1;
    localparam int LZS_CNT_W   = lzs_clog2(LZS_ACC_W + 1);
    localparam int LZS_BYTES_W = lzs_clog2(LZS_OUT_W / 8) + 1;
    localparam int LZS_CHUNKS  = LZS_OUT_W / LZS_WORD_W;

endpackage

// File: rtl/lzs_sync_fifo.sv
// lzs_sync_fifo: first-word-fall-through FIFO for packed output words.
// Push while full is accepted when a pop happens in the same cycle.
// dout reads as zero while empty so an idle head never shows stale data.
module lzs_sync_fifo
    import lzs_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PW = lzs_clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign dout    = empty ? '0 : mem[rd_ptr[PW-1:0]];

    // Storage write; contents need no reset since the head is gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= din;
    end

    // Read/write pointers with a wrap bit to tell full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/lzs_bitpack_out.sv
// lzs_bitpack_out: packs MSB-first variable-length LZS code fields into a bit
// stream, drains WORD_W chunks (byte-swapped) into an OUT_W word assembler and
// queues finished words in an output FIFO. End of stream flushes a final,
// right-aligned partial word carrying its byte count and out_last.
// Optional build macro: LZS_BITPACK_STATS_EN adds stat_bits/stat_words.
module lzs_bitpack_out
    import lzs_pkg::*;
#(
    parameter int CODE_W     = LZS_CODE_W,
    parameter int LEN_W      = LZS_LEN_W,
    parameter int WORD_W     = LZS_WORD_W,
    parameter int OUT_W      = LZS_OUT_W,
    parameter int FIFO_DEPTH = LZS_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CODE_W-1:0]             in_code,
    input  logic [LEN_W-1:0]              in_len,
    input  logic                          in_finish,
    input  logic                          clr,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              out_data,
    output logic [lzs_clog2(OUT_W/8):0]   out_bytes,
    output logic                          out_last,
    output logic                          done
`ifdef LZS_BITPACK_STATS_EN
    ,
    output logic [31:0]                   stat_bits,
    output logic [19:0]                   stat_words
`endif
);

    localparam int ACC_W   = CODE_W + WORD_W - 1;
    localparam int CNT_W   = lzs_clog2(ACC_W + 1);
    localparam int BYTES_W = lzs_clog2(OUT_W / 8) + 1;
    localparam int CHUNKS  = OUT_W / WORD_W;
    localparam int CH_W    = lzs_clog2(CHUNKS + 1);
    localparam int AB_W    = lzs_clog2(OUT_W + 1);

    typedef struct packed {
        logic               last;
        logic [BYTES_W-1:0] bytes;
        logic [OUT_W-1:0]   data;
    } word_t;

    lzs_state_e        state;
    logic              started;
    logic              done_r;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic [OUT_W-1:0]  asm_data;
    logic [CH_W-1:0]   asm_cnt;
    logic [AB_W-1:0]   asm_bits;

    logic              accept;
    logic              pop;
    logic              asm_full;
    logic              fifo_ok;
    logic              drain_full;
    logic              drain_part;
    logic              final_push;
    logic              push;
    logic              push_last;
    logic [CODE_W-1:0] mask;
    logic [ACC_W-1:0]  acc_sh;
    logic [WORD_W-1:0] raw;
    logic [WORD_W-1:0] chunk_sw;
    logic [AB_W-1:0]   push_shift;
    word_t             push_w;
    word_t             head_w;
    logic              fifo_full;
    logic              fifo_empty;

    // Input side is closed for the first cycle after reset and outside RUN.
    assign in_ready = started && (state == RUN) && (cnt < CNT_W'(WORD_W));
    assign pop      = out_valid && out_ready;
    assign mask     = ~({CODE_W{1'b1}} << in_len);

    // Handshake and drain/push decisions. Accept needs cnt<WORD_W and a full
    // drain needs cnt>=WORD_W, so the accumulator never sees both at once.
    always_comb begin
        accept     = in_valid && in_ready;
        asm_full   = (asm_cnt == CH_W'(CHUNKS));
        fifo_ok    = !fifo_full || pop;
        drain_full = !asm_full && (cnt >= CNT_W'(WORD_W));
        drain_part = (state == FLUSH) && !asm_full && (cnt != '0) && (cnt < CNT_W'(WORD_W));
        final_push = (state == FLUSH) && !asm_full && (cnt == '0) && fifo_ok;
        push       = (asm_full && fifo_ok) || final_push;
        // In FLUSH with the accumulator empty, whatever leaves now ends the stream.
        push_last  = (state == FLUSH) && (cnt == '0);
    end

    // Chunk extraction: oldest WORD_W bits, or the zero-padded residue in
    // FLUSH; then swap bytes so the first stream bit lands in byte 0's MSB.
    always_comb begin
        acc_sh   = acc >> (cnt - CNT_W'(WORD_W));
        raw      = drain_part ? (acc[WORD_W-1:0] << (CNT_W'(WORD_W) - cnt))
                              : acc_sh[WORD_W-1:0];
        chunk_sw = '0;
        for (int b = 0; b < WORD_W / 8; b++)
            chunk_sw[8*b +: 8] = raw[WORD_W-8-8*b +: 8];
    end

    // Outgoing word: chunks enter from the top, so a partial word is shifted
    // down until its earliest chunk sits in bits [WORD_W-1:0].
    always_comb begin
        push_shift   = AB_W'(OUT_W - int'(asm_cnt) * WORD_W);
        push_w       = '0;
        push_w.data  = asm_data >> push_shift;
        push_w.bytes = BYTES_W'((int'(asm_bits) + 7) / 8);
        push_w.last  = push_last;
    end

    // Bit accumulator and chunk assembler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            asm_data <= '0;
            asm_cnt  <= '0;
            asm_bits <= '0;
        end else begin
            if (accept) begin
                acc <= (acc << in_len) | ACC_W'(in_code & mask);
                cnt <= cnt + CNT_W'(in_len);
            end else if (drain_full) begin
                cnt <= cnt - CNT_W'(WORD_W);
            end else if (drain_part) begin
                cnt <= '0;
            end

            if (drain_full || drain_part) begin
                asm_data <= (asm_data >> WORD_W) | (OUT_W'(chunk_sw) << (OUT_W - WORD_W));
                asm_cnt  <= asm_cnt + 1'b1;
                asm_bits <= asm_bits + (drain_full ? AB_W'(WORD_W) : AB_W'(cnt));
            end else if (push) begin
                asm_cnt  <= '0;
                asm_bits <= '0;
            end
        end
    end

    // Stream FSM: RUN until finish with nothing pending, FLUSH until the
    // final word is queued, DONE until clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            started <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            started <= 1'b1;
            case (state)
                RUN: begin
                    if (in_finish && (!in_valid || accept)) state <= FLUSH;
                end
                FLUSH: begin
                    if (push && push_last) begin
                        state  <= DONE;
                        done_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (clr) begin
                        state  <= RUN;
                        done_r <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    lzs_sync_fifo #(
        .W     ($bits(word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_w),
        .dout  (head_w),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = head_w.data;
    assign out_bytes = head_w.bytes;
    assign out_last  = head_w.last;
    assign done      = done_r;

`ifdef LZS_BITPACK_STATS_EN
    // Stream statistics; clr wipes them in any state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_bits  <= '0;
            stat_words <= '0;
        end else if (clr) begin
            stat_bits  <= '0;
            stat_words <= '0;
        end else begin
            if (accept) stat_bits  <= stat_bits + 32'(in_len);
            if (pop)    stat_words <= stat_words + 20'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lzs_bitpack_out.sv
// tb_lzs_bitpack_out: directed bench for lzs_bitpack_out (default parameters).
module tb_lzs_bitpack_out;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [12:0] in_code = '0;
    logic [3:0]  in_len = '0;
    logic        in_finish = 1'b0;
    logic        clr = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic [3:0]  out_bytes;
    logic        out_last;
    logic        done;
`ifdef LZS_BITPACK_STATS_EN
    logic [31:0] stat_bits;
    logic [19:0] stat_words;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  bytes;
        logic        last;
    } wd_t;

    wd_t q[$];
    bit  exp_bits[$];

    lzs_bitpack_out dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_len    (in_len),
        .in_finish (in_finish),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_bytes (out_bytes),
        .out_last  (out_last),
        .done      (done)
`ifdef LZS_BITPACK_STATS_EN
        ,
        .stat_bits (stat_bits),
        .stat_words(stat_words)
`endif
    );

    always #5 clk = ~clk;

    // Record every word the sink takes.
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) q.push_back('{out_data, out_bytes, out_last});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [12:0] code, input logic [3:0] len, input logic fin);
        int n;
        n = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_code   = code;
        in_len    = len;
        in_finish = fin;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_ready_timeout", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_finish = 1'b0;
    endtask

    task automatic wait_words(input int n);
        int k;
        k = 0;
        while (q.size() < n && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("word_count", 64'(q.size()), 64'(n));
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Expected word w from the recorded bit stream: stream bytes in
    // little-endian byte order, first bit of each byte in its MSB.
    function automatic logic [63:0] model_word(input int w);
        logic [63:0] d;
        int idx;
        d = '0;
        for (int j = 0; j < 8; j++) begin
            for (int t = 0; t < 8; t++) begin
                idx = 64 * w + 8 * j + t;
                if (idx < exp_bits.size()) d[8*j + 7 - t] = exp_bits[idx];
            end
        end
        return d;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int nacc;
        int nw;
        int rem;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 64'h0);
        check("rst_out_bytes", out_bytes, 4'd0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready_hold", in_ready, 1'b0);
        @(negedge clk);
        check("post_rst_ready", in_ready, 1'b1);

        // 0x1234,0x5678,0x9ABC,0xDEF0 as mixed-length fields (junk above len
        // must be masked), finish with the word-completing field.
        send(13'h0246, 4'd13, 1'b0);
        send(13'h0004, 4'd3,  1'b0);
        send(13'h1F56, 4'd8,  1'b0);
        send(13'h0078, 4'd8,  1'b0);
        send(13'h09AB, 4'd12, 1'b0);
        send(13'h000C, 4'd4,  1'b0);
        send(13'h00DE, 4'd8,  1'b0);
        send(13'h00F0, 4'd8,  1'b1);
        check("lat_e0_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        check("lat_e1_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        check("lat_e2_valid", out_valid, 1'b1);
        check("lat_e2_data", out_data, 64'hF0DEBC9A78563412);
        check("exact_done", done, 1'b1);
        wait_words(1);
        check("w0_data", q[0].data, 64'hF0DEBC9A78563412);
        check("w0_bytes", q[0].bytes, 4'd8);
        check("w0_last", q[0].last, 1'b1);
        repeat (5) @(negedge clk);
        check("exact_no_extra", 64'(q.size()), 64'd1);
        check("exact_in_ready_done", in_ready, 1'b0);
        pulse_clr();
        check("clr_ready", in_ready, 1'b1);
        check("clr_done", done, 1'b0);

        // 8 x 9-bit ones (junk above bit 8 on odd fields) -> 72 bits.
        for (int i = 0; i < 8; i++)
            send((i % 2 == 1) ? 13'h1FFF : 13'h01FF, 4'd9, (i == 7));
        wait_words(3);
        check("ff_w1_data", q[1].data, 64'hFFFF_FFFF_FFFF_FFFF);
        check("ff_w1_bytes", q[1].bytes, 4'd8);
        check("ff_w1_last", q[1].last, 1'b0);
        check("ff_w2_data", q[2].data, 64'h0000_0000_0000_00FF);
        check("ff_w2_bytes", q[2].bytes, 4'd1);
        check("ff_w2_last", q[2].last, 1'b1);
        check("ff_done", done, 1'b1);
        pulse_clr();

        // Empty stream.
        @(negedge clk);
        in_finish = 1'b1;
        @(negedge clk);
        in_finish = 1'b0;
        wait_words(4);
        check("empty_data", q[3].data, 64'h0);
        check("empty_bytes", q[3].bytes, 4'd0);
        check("empty_last", q[3].last, 1'b1);
        check("empty_done", done, 1'b1);
        pulse_clr();
        check("empty_clr_ready", in_ready, 1'b1);

        // Backpressure: sink stalled, continuous 13-bit fields.
        out_ready = 1'b0;
        base = q.size();
        nacc = 0;
        exp_bits.delete();
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_len   = 4'd13;
            in_code  = 13'(nacc * 613 + 77);
            if (in_ready) begin
                for (int b = 12; b >= 0; b--) exp_bits.push_back(in_code[b]);
                nacc++;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_accepted", 64'(nacc), 64'd26);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_out_valid", out_valid, 1'b1);
        check("bp_no_pop", 64'(q.size()), 64'(base));
        out_ready = 1'b1;
        in_finish = 1'b1;
        @(negedge clk);
        in_finish = 1'b0;
        nw = (exp_bits.size() + 63) / 64;
        wait_words(base + nw);
        for (int w = 0; w < nw; w++) begin
            rem = exp_bits.size() - 64 * w;
            check($sformatf("bp_w%0d_data", w), q[base + w].data, model_word(w));
            check($sformatf("bp_w%0d_bytes", w), q[base + w].bytes, 64'((rem >= 64) ? 8 : (rem + 7) / 8));
            check($sformatf("bp_w%0d_last", w), q[base + w].last, (w == nw - 1));
        end
        check("bp_done", done, 1'b1);
        pulse_clr();

        // Async reset mid-stream: one word queued, 11 bits in the accumulator.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(13'h00A5, 4'd8, 1'b0);
        send(13'h0005, 4'd3, 1'b0);
        send(13'h00AB, 4'd8, 1'b0);
        repeat (3) @(negedge clk);
        check("mid_out_valid", out_valid, 1'b1);
        check("mid_in_ready", in_ready, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b0);
        check("mid_rst_out_data", out_data, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        base = q.size();
        @(negedge clk);
        send(13'h0246, 4'd13, 1'b0);
        send(13'h0004, 4'd3,  1'b0);
        send(13'h0056, 4'd8,  1'b0);
        send(13'h0078, 4'd8,  1'b0);
        send(13'h09AB, 4'd12, 1'b0);
        send(13'h000C, 4'd4,  1'b0);
        send(13'h00DE, 4'd8,  1'b0);
        send(13'h00F0, 4'd8,  1'b1);
        wait_words(base + 1);
        repeat (4) @(negedge clk);
        check("clean_count", 64'(q.size()), 64'(base + 1));
        check("clean_data", q[base].data, 64'hF0DEBC9A78563412);
        check("clean_bytes", q[base].bytes, 4'd8);
        check("clean_last", q[base].last, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
